// File: rtl/fp16_addsub_norm_round.sv
// Binary16 add/sub back end: mantissa add/sub, normalize, round-to-nearest-even, pack.
// Three-stage valid/ready pipeline with one global advance enable.
module fp16_addsub_norm_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_a_half,
  input  logic        sign_b_half,
  input  logic [13:0] in_mant_a_half_ext,
  input  logic [13:0] in_mant_b_half_ext,
  input  logic [4:0]  in_exp_half,
  input  logic        in_special,
  input  logic [15:0] in_special_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result_half,
  output logic [2:0]  out_flags
);
  localparam int unsigned MANT_W = 14;
  localparam int unsigned SUM_W  = 15;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned EXPX_W = 6;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned FLAG_W = 3;

  logic adv;

  logic              s1_valid, s1_special, s1_sign;
  logic [RES_W-1:0]  s1_special_result;
  logic [SUM_W-1:0]  s1_sum;
  logic [EXP_W-1:0]  s1_exp;

  logic              s2_valid, s2_special, s2_sign, s2_tiny;
  logic [RES_W-1:0]  s2_special_result;
  logic [MANT_W-1:0] s2_mant;
  logic [EXPX_W-1:0] s2_exp;

  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Stage 1: magnitude add, or larger-minus-smaller with the larger operand's sign
  logic             eff_sub;
  logic [SUM_W-1:0] sum_c;
  logic             sign_c;
  always_comb begin
    eff_sub = sign_a_half ^ sign_b_half;
    sum_c   = '0;
    sign_c  = sign_a_half;
    if (!eff_sub) begin
      sum_c = SUM_W'(in_mant_a_half_ext) + SUM_W'(in_mant_b_half_ext);
    end else if (in_mant_a_half_ext > in_mant_b_half_ext) begin
      sum_c = SUM_W'(in_mant_a_half_ext - in_mant_b_half_ext);
    end else if (in_mant_b_half_ext > in_mant_a_half_ext) begin
      sum_c  = SUM_W'(in_mant_b_half_ext - in_mant_a_half_ext);
      sign_c = sign_b_half;
    end else begin
      sign_c = 1'b0;
    end
  end

  // Stage 2: normalize; left shift is capped so the exponent never drops below 1
  logic [3:0]        lz;
  logic [EXP_W-1:0]  shift;
  logic [MANT_W-1:0] norm_mant;
  logic [EXPX_W-1:0] norm_exp;
  logic              norm_tiny;
  always_comb begin
    lz = 4'(MANT_W);
    for (int i = 0; i < MANT_W; i++) begin
      if (s1_sum[i]) lz = 4'(MANT_W - 1 - i);
    end
    shift     = (5'(lz) < s1_exp - 5'd1) ? 5'(lz) : s1_exp - 5'd1;
    norm_mant = s1_sum[MANT_W-1:0] << shift;
    norm_exp  = EXPX_W'(s1_exp) - EXPX_W'(shift);
    if (s1_sum[SUM_W-1]) begin
      norm_mant = {s1_sum[14:2], s1_sum[1] | s1_sum[0]};
      norm_exp  = EXPX_W'(s1_exp) + 6'd1;
    end
    norm_tiny = !norm_mant[MANT_W-1];
    if (norm_tiny) norm_exp = '0;
  end

  // Stage 3: round to nearest even, handle carry-out, overflow to infinity, pack
  logic              inexact, round_up;
  logic [11:0]       m11;
  logic [EXPX_W-1:0] rnd_exp;
  logic [RES_W-1:0]  res_c;
  logic [FLAG_W-1:0] flags_c;
  always_comb begin
    inexact  = |s2_mant[2:0];
    round_up = s2_mant[2] & (s2_mant[3] | s2_mant[1] | s2_mant[0]);
    m11      = 12'(s2_mant[13:3]) + 12'(round_up);
    rnd_exp  = s2_exp;
    if (m11[11]) begin
      m11     = m11 >> 1;
      rnd_exp = s2_exp + 6'd1;
    end
    if (s2_tiny && m11[10]) rnd_exp = 6'd1;
    res_c   = {s2_sign, rnd_exp[4:0], m11[9:0]};
    flags_c = {1'b0, s2_tiny & inexact, inexact};
    if (rnd_exp >= 6'd31) begin
      res_c   = {s2_sign, 15'h7C00};
      flags_c = 3'b101;
    end
    if (s2_special) begin
      res_c   = s2_special_result;
      flags_c = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid          <= 1'b0;
      s1_special        <= 1'b0;
      s1_sign           <= 1'b0;
      s1_special_result <= '0;
      s1_sum            <= '0;
      s1_exp            <= '0;
      s2_valid          <= 1'b0;
      s2_special        <= 1'b0;
      s2_sign           <= 1'b0;
      s2_tiny           <= 1'b0;
      s2_special_result <= '0;
      s2_mant           <= '0;
      s2_exp            <= '0;
      out_valid         <= 1'b0;
      out_result_half   <= '0;
      out_flags         <= '0;
    end else if (adv) begin
      s1_valid          <= in_valid;
      s1_special        <= in_special;
      s1_sign           <= sign_c;
      s1_special_result <= in_special_result;
      s1_sum            <= sum_c;
      s1_exp            <= in_exp_half;
      s2_valid          <= s1_valid;
      s2_special        <= s1_special;
      s2_sign           <= s1_sign;
      s2_tiny           <= norm_tiny;
      s2_special_result <= s1_special_result;
      s2_mant           <= norm_mant;
      s2_exp            <= norm_exp;
      out_valid         <= s2_valid;
      out_result_half   <= res_c;
      out_flags         <= flags_c;
    end
  end
endmodule

// File: tb/tb_fp16_addsub_norm_round.sv
// Self-checking bench: directed table, stall/reset sequences and random ops vs an exact-arithmetic model.
module tb_fp16_addsub_norm_round;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic        sign_a_half, sign_b_half;
  logic [13:0] in_mant_a_half_ext, in_mant_b_half_ext;
  logic [4:0]  in_exp_half;
  logic        in_special;
  logic [15:0] in_special_result;
  logic        out_valid, out_ready;
  logic [15:0] out_result_half;
  logic [2:0]  out_flags;

  fp16_addsub_norm_round dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign_a_half(sign_a_half), .sign_b_half(sign_b_half),
    .in_mant_a_half_ext(in_mant_a_half_ext), .in_mant_b_half_ext(in_mant_b_half_ext),
    .in_exp_half(in_exp_half), .in_special(in_special), .in_special_result(in_special_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result_half(out_result_half), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sa;
    logic        sb;
    logic [13:0] ma;
    logic [13:0] mb;
    logic [4:0]  e;
    logic        sp;
    logic [15:0] spr;
    logic [15:0] res;
    logic [2:0]  fl;
  } vec_t;

  typedef struct packed {
    logic [15:0] res;
    logic [2:0]  fl;
  } exp_t;

  exp_t        sbq[$];
  vec_t        tbl[$];
  int          checks = 0;
  int          passes = 0;
  logic        obs_valid, obs_ready;
  logic [15:0] obs_result;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic vec_t mk(input logic sa, input logic sb, input logic [13:0] ma, input logic [13:0] mb,
                              input logic [4:0] e, input logic sp, input logic [15:0] spr,
                              input logic [15:0] res, input logic [2:0] fl);
    vec_t v;
    v.sa = sa; v.sb = sb; v.ma = ma; v.mb = mb; v.e = e;
    v.sp = sp; v.spr = spr; v.res = res; v.fl = fl;
    return v;
  endfunction

  // Exact signed sum in units of 2^(e-28), then rounded to binary16 by value
  function automatic exp_t model(input vec_t v);
    exp_t r;
    int   d, m, p, ue, q, k, qt, rem, half, fld, ev;
    logic sgn, tiny, inexact, up;
    if (v.sp) begin
      r.res = v.spr; r.fl = 3'b000;
      return r;
    end
    ev = int'(v.e);
    d  = (v.sa ? -int'(v.ma) : int'(v.ma)) + (v.sb ? -int'(v.mb) : int'(v.mb));
    if (d == 0) begin
      r.res = {(v.sa == v.sb) ? v.sa : 1'b0, 15'h0000};
      r.fl  = 3'b000;
      return r;
    end
    sgn = (d < 0);
    m   = sgn ? -d : d;
    p   = 0;
    for (int i = 0; i < 16; i++) if (((m >> i) & 1) != 0) p = i;
    ue   = p + ev - 28;
    tiny = (ue < -14);
    q    = tiny ? -24 : ue - 10;
    k    = q - (ev - 28);
    if (k <= 0) begin
      qt = m << (-k);
      inexact = 1'b0;
    end else begin
      qt   = m >> k;
      rem  = m & ((1 << k) - 1);
      half = 1 << (k - 1);
      up   = (rem > half) || (rem == half && (qt & 1) == 1);
      inexact = (rem != 0);
      qt = qt + (up ? 1 : 0);
    end
    if (qt == 2048) begin
      qt = 1024;
      q  = q + 1;
    end
    fld = (tiny && qt < 1024) ? 0 : q + 25;
    if (fld >= 31) begin
      r.res = sgn ? 16'hFC00 : 16'h7C00;
      r.fl  = 3'b101;
    end else begin
      r.res = {sgn, 5'(fld), 10'(qt & 1023)};
      r.fl  = {1'b0, tiny & inexact, inexact};
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    exp_t r;
    v.sa  = 1'($urandom_range(0, 1));
    v.sb  = 1'($urandom_range(0, 1));
    v.ma  = 14'($urandom);
    v.mb  = 14'($urandom);
    if ($urandom_range(0, 1) == 1) v.ma[13] = 1'b1;
    if ($urandom_range(0, 9) == 0) v.mb = v.ma;
    v.e   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 3)) : 5'($urandom_range(1, 30));
    v.sp  = ($urandom_range(0, 15) == 0);
    v.spr = 16'($urandom);
    r     = model(v);
    v.res = r.res;
    v.fl  = r.fl;
    return v;
  endfunction

  // One clock: drive at negedge, sample 1 time unit later, score what fires at the next posedge
  task automatic cycle(input logic v, input vec_t x, input logic ordy);
    exp_t t;
    @(negedge clk);
    in_valid = v; sign_a_half = x.sa; sign_b_half = x.sb;
    in_mant_a_half_ext = x.ma; in_mant_b_half_ext = x.mb; in_exp_half = x.e;
    in_special = x.sp; in_special_result = x.spr; out_ready = ordy;
    #1;
    obs_valid = out_valid; obs_ready = in_ready; obs_result = out_result_half;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL spurious_result: got %h want no output", out_result_half);
      end else begin
        t = sbq.pop_front();
        check("result", 32'(out_result_half), 32'(t.res));
        check("flags", 32'(out_flags), 32'(t.fl));
      end
    end
    if (in_valid && in_ready) begin
      t.res = x.res; t.fl = x.fl;
      sbq.push_back(t);
    end
  endtask

  task automatic drain();
    vec_t z;
    z = mk(1'b0, 1'b0, 14'h0, 14'h0, 5'd1, 1'b0, 16'h0, 16'h0, 3'b000);
    for (int i = 0; i < 30 && sbq.size() > 0; i++) cycle(1'b0, z, 1'b1);
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    vec_t x;
    z = mk(1'b0, 1'b0, 14'h0, 14'h0, 5'd1, 1'b0, 16'h0, 16'h0, 3'b000);
    tbl.push_back(mk(1'b0, 1'b0, 14'h2000, 14'h2000, 5'd15, 1'b0, 16'h0,    16'h4000, 3'b000));
    tbl.push_back(mk(1'b0, 1'b1, 14'h2000, 14'h2000, 5'd15, 1'b0, 16'h0,    16'h0000, 3'b000));
    tbl.push_back(mk(1'b0, 1'b0, 14'h2000, 14'h0004, 5'd15, 1'b0, 16'h0,    16'h3C00, 3'b001));
    tbl.push_back(mk(1'b0, 1'b0, 14'h2008, 14'h0004, 5'd15, 1'b0, 16'h0,    16'h3C02, 3'b001));
    tbl.push_back(mk(1'b0, 1'b0, 14'h3FF8, 14'h3FF8, 5'd30, 1'b0, 16'h0,    16'h7C00, 3'b101));
    tbl.push_back(mk(1'b1, 1'b1, 14'h3FF8, 14'h3FF8, 5'd30, 1'b0, 16'h0,    16'hFC00, 3'b101));
    tbl.push_back(mk(1'b0, 1'b1, 14'h1234, 14'h0777, 5'd7,  1'b1, 16'h7E00, 16'h7E00, 3'b000));
    tbl.push_back(mk(1'b0, 1'b0, 14'h1FFC, 14'h0004, 5'd1,  1'b0, 16'h0,    16'h0400, 3'b000));
    tbl.push_back(mk(1'b0, 1'b0, 14'h1FFC, 14'h0000, 5'd1,  1'b0, 16'h0,    16'h0400, 3'b011));
    tbl.push_back(mk(1'b0, 1'b1, 14'h2000, 14'h1FF8, 5'd15, 1'b0, 16'h0,    16'h1400, 3'b000));
    tbl.push_back(mk(1'b0, 1'b1, 14'h2000, 14'h3000, 5'd15, 1'b0, 16'h0,    16'hB800, 3'b000));
    tbl.push_back(mk(1'b0, 1'b0, 14'h3FFC, 14'h0000, 5'd15, 1'b0, 16'h0,    16'h4000, 3'b001));

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sign_a_half = 1'b0; sign_b_half = 1'b0; in_mant_a_half_ext = '0; in_mant_b_half_ext = '0;
    in_exp_half = 5'd1; in_special = 1'b0; in_special_result = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", 32'(out_result_half), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Latency: result appears exactly three edges after acceptance
    cycle(1'b1, tbl[0], 1'b1);
    cycle(1'b0, z, 1'b1); check("lat_edge1", 32'(obs_valid), 32'd0);
    cycle(1'b0, z, 1'b1); check("lat_edge2", 32'(obs_valid), 32'd0);
    cycle(1'b0, z, 1'b1); check("lat_edge3", 32'(obs_valid), 32'd1);
    drain();

    foreach (tbl[i]) cycle(1'b1, tbl[i], 1'b1);
    drain();

    // Backpressure: three accepts, then a 4-cycle stall with a pending offer
    cycle(1'b1, tbl[2], 1'b1);
    cycle(1'b1, tbl[3], 1'b1);
    cycle(1'b1, tbl[8], 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, tbl[9], 1'b0);
      check("stall_in_ready", 32'(obs_ready), 32'd0);
      check("stall_valid", 32'(obs_valid), 32'd1);
      check("stall_hold", 32'(obs_result), 32'(sbq[0].res));
    end
    cycle(1'b1, tbl[9], 1'b1);
    drain();

    // Reset with operations in flight discards them
    cycle(1'b1, tbl[0], 1'b1);
    cycle(1'b1, tbl[2], 1'b1);
    cycle(1'b0, z, 1'b0);
    cycle(1'b0, z, 1'b0);
    check("pre_rst_valid", 32'(obs_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(out_result_half), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, z, 1'b1);
      check("post_rst_idle", 32'(obs_valid), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      x = rand_vec();
      cycle(1'($urandom_range(0, 3) != 0), x, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
